fpu_apu_arbiter: RTL
====================

# fpu_apu_arbiter

Shares one `fp_wrapper` floating-point unit between `NUM_REQ` APU-style requesters, such as core issue ports or an accelerator. It is placed between the requesters and the FPU's master port. It round-robin arbitrates requests and tracks the owner of every in-flight operation in an in-order owner FIFO. Each FPU response is routed back to the requester that issued it.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (≥2).
- `MAX_OUTST`, 2: maximum in-flight FPU operations, which is also the owner FIFO depth (power of two).
- `WDOG_CYCLES`, 64: watchdog limit in cycles; only used when `FPU_ARB_WDOG_EN` is defined.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk_i`  in  1  clock.
  - `rst_i`  in  1  synchronous reset.
- Requester side:
  - `req_i`  in  NUM_REQ  per-requester request.
  - `gnt_o`  out  NUM_REQ  per-requester grant.
  - `operands_i`  in  NUM_REQ×3×32  operands.
  - `op_i`  in  NUM_REQ×6  opcode.
  - `flags_i`  in  NUM_REQ×11  op flags, including rounding mode.
  - `rvalid_o`  out  NUM_REQ  per-requester response valid.
  - `rdata_o`  out  32  result, shared by all requesters.
  - `rflags_o`  out  5  exception flags, shared by all requesters.
- FPU side:
  - `fpu_req_o`  out  1.
  - `fpu_gnt_i`  in  1.
  - `fpu_operands_o`  out  3×32.
  - `fpu_op_o`  out  6.
  - `fpu_flags_o`  out  11.
  - `fpu_rvalid_i`  in  1.
  - `fpu_rdata_i`  in  32.
  - `fpu_rflags_i`  in  5.
- Status:
  - `busy_o`  out  1  FIFO non-empty.
  - `spurious_o`  out  1  one-cycle pulse when `fpu_rvalid_i` arrives with an empty FIFO.
  - `wdog_err_o`  out  1  sticky watchdog error.

## Operation
- Requester handshake: a requester holds `req_i` and its payload stable until it sees `gnt_o`. The transfer happens in the cycle where `req_i & gnt_o`.
- Selection:
  - The selected requester is the first requester with `req_i` set, searching from `rr_ptr` upward with wrap-around.
  - Its payload is muxed onto the FPU outputs.
  - `fpu_req_o = |req_i & ~full`.
- Grant: `gnt_o[sel] = fpu_gnt_i & fpu_req_o`. All other grant bits are 0.
- On a grant:
  - `sel` is pushed into the owner FIFO.
  - `rr_ptr` becomes `(sel+1) mod NUM_REQ`.
  - `rr_ptr` does not change in cycles without a grant.
- Response:
  - On `fpu_rvalid_i` with a non-empty FIFO, `rvalid_o[head] = 1`, `rdata_o = fpu_rdata_i`, `rflags_o = fpu_rflags_i`, and the FIFO is popped.
  - The FPU returns responses strictly in order.
- Spurious response: `fpu_rvalid_i` with an empty FIFO is dropped and `spurious_o` pulses for one cycle.
- State machine, derived from the FIFO count:
  - IDLE (count 0), ACTIVE (0 < count < MAX_OUTST), FULL (count = MAX_OUTST).
  - Push only: count+1. Pop only: count−1. Push and pop together: count unchanged.
- Full boundary: in FULL, `fpu_req_o = 0` even if a pop happens in the same cycle. Granting resumes the next cycle.

## Timing
- Grant is combinational, in the same cycle as `fpu_gnt_i`.
- Response routing is zero-latency combinational pass-through.
- The FIFO count, `rr_ptr` and the watchdog update on the rising edge of `clk_i`.
- Reset values:
  - `gnt_o = 0`, `rvalid_o = 0`, `fpu_req_o = 0` (forced while `rst_i` is high).
  - `rdata_o = 0`, `rflags_o = 0`.
  - `busy_o = 0`, `spurious_o = 0`, `wdog_err_o = 0`.
  - `rr_ptr = 0`, FIFO count = 0, watchdog counter = 0.
- Reset mid-operation: owner entries are discarded. Any later `fpu_rvalid_i` is treated as spurious.

## Configuration
`FPU_ARB_WDOG_EN`:
- Defined:
  - A counter increments every cycle the FIFO is non-empty without `fpu_rvalid_i`. It clears on `fpu_rvalid_i` or when the FIFO is empty.
  - When the counter reaches `WDOG_CYCLES`, the arbiter synthesises a response to the head owner: `rdata_o = 32'h7FC00000`, `rflags_o = 5'b10000` (NV). It then pops the FIFO, sets `wdog_err_o` (sticky until reset) and clears the counter.
  - If `fpu_rvalid_i` arrives in the same cycle the counter reaches the limit, the real response wins.
- Undefined: the watchdog logic is absent and `wdog_err_o` is tied to 0.

## Structure
- Package `fpu_arb_pkg` holds:
  - `OP_W=6`, `FLAGS_W=11`, `NUM_OPS=3`, `RFLAGS_W=5`.
  - `CANON_NAN=32'h7FC00000`, `FLAG_NV=5'b10000`.
  - The request payload struct typedef.
- Sub-module `fpu_arb_owner_fifo` holds the owner FIFO: `$clog2(NUM_REQ)`-bit entries with push, pop, full, empty and count.

## Test plan
Bench stub FPU: `fpu_gnt_i = 1`, fixed latency L.
1. Single operation: `req_i = 2'b01`, op `6'b000010`, operands `41000000` / `40800000`, L=3, stub result `41400000` → `gnt_o = 01` in the same cycle; 3 cycles later `rvalid_o = 01`, `rdata_o = 41400000`; `rvalid_o[1]` stays 0.
2. Round-robin fairness: `req_i = 2'b11` held across 4 grants, L=1 → grant order 0, 1, 0, 1; responses routed in that order.
3. Full boundary: MAX_OUTST=2, L=10, three back-to-back requests → the third is granted only in the cycle after the first `rvalid_o`.
4. FPU back-pressure: `fpu_gnt_i = 0` for 5 cycles with `req_i = 2'b10` → `gnt_o = 0`, `fpu_req_o = 1`, payload stable, `rr_ptr` unchanged.
5. Watchdog (`FPU_ARB_WDOG_EN`, WDOG_CYCLES=8): stub never responds → 8 cycles after the grant, `rvalid_o[0] = 1`, `rdata_o = 7FC00000`, `rflags_o = 10000`, `wdog_err_o = 1`.
6. Reset mid-operation: `rst_i` pulsed with 2 operations in flight → `busy_o = 0`; a late `fpu_rvalid_i` produces a `spurious_o` pulse and no `rvalid_o`.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU/APU arbiter.
package fpu_arb_pkg;
  localparam int OP_W     = 6;
  localparam int FLAGS_W  = 11;
  localparam int NUM_OPS  = 3;
  localparam int RFLAGS_W = 5;
  localparam int DATA_W   = 32;

  localparam logic [DATA_W-1:0]   CANON_NAN = 32'h7FC00000;
  localparam logic [RFLAGS_W-1:0] FLAG_NV   = 5'b10000;

  typedef struct packed {
    logic [NUM_OPS*DATA_W-1:0] operands;
    logic [OP_W-1:0]           op;
    logic [FLAGS_W-1:0]        flags;
  } fpu_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACTIVE,
    ARB_FULL
  } arb_state_e;
endpackage

// File: rtl/fpu_arb_owner_fifo.sv
// In-order owner FIFO: remembers which requester issued each in-flight FPU op.
module fpu_arb_owner_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_q, rd_q;
  logic                    push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fpu_apu_arbiter.sv
// Round-robin arbiter sharing one FPU between NUM_REQ APU requesters, routing
// in-order responses back by owner. Optional watchdog: define FPU_ARB_WDOG_EN.
module fpu_apu_arbiter import fpu_arb_pkg::*; #(
  parameter int NUM_REQ     = 2,
  parameter int MAX_OUTST   = 2,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_REQ-1:0]                     req_i,
  output logic [NUM_REQ-1:0]                     gnt_o,
  input  logic [NUM_REQ-1:0][NUM_OPS*DATA_W-1:0] operands_i,
  input  logic [NUM_REQ-1:0][OP_W-1:0]           op_i,
  input  logic [NUM_REQ-1:0][FLAGS_W-1:0]        flags_i,
  output logic [NUM_REQ-1:0]                     rvalid_o,
  output logic [DATA_W-1:0]                      rdata_o,
  output logic [RFLAGS_W-1:0]                    rflags_o,
  output logic                                   fpu_req_o,
  input  logic                                   fpu_gnt_i,
  output logic [NUM_OPS*DATA_W-1:0]              fpu_operands_o,
  output logic [OP_W-1:0]                        fpu_op_o,
  output logic [FLAGS_W-1:0]                     fpu_flags_o,
  input  logic                                   fpu_rvalid_i,
  input  logic [DATA_W-1:0]                      fpu_rdata_i,
  input  logic [RFLAGS_W-1:0]                    fpu_rflags_i,
  output logic                                   busy_o,
  output logic                                   spurious_o,
  output logic                                   wdog_err_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTST) + 1;

  logic [IW-1:0]              rr_q, sel, head;
  logic [CW-1:0]              count, cnt_nxt;
  logic                       any_req, fifo_full, fifo_empty, has_owner;
  logic                       grant, pop, rsp_real, wdog_fire;
  arb_state_e                 state_q, state_d;
  fpu_req_t [NUM_REQ-1:0]     req_pl;
  fpu_req_t                   sel_pl;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pl
    assign req_pl[g] = {operands_i[g], op_i[g], flags_i[g]};
  end

  // Walk downward so the requester closest to rr_q is the last (winning) hit.
  always_comb begin
    sel     = rr_q;
    any_req = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      int idx;
      idx = int'(rr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_i[idx]) begin
        sel     = IW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign sel_pl         = req_pl[sel];
  assign fpu_operands_o = sel_pl.operands;
  assign fpu_op_o       = sel_pl.op;
  assign fpu_flags_o    = sel_pl.flags;

  assign has_owner = ~fifo_empty;
  assign fpu_req_o = ~rst_i & any_req & ~fifo_full;
  assign grant     = fpu_req_o & fpu_gnt_i;
  assign rsp_real  = has_owner & fpu_rvalid_i;
  assign pop       = ~rst_i & (rsp_real | wdog_fire);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
    assign gnt_o[g]    = grant & (sel == IW'(g));
    assign rvalid_o[g] = pop & (head == IW'(g));
  end

  always_comb begin
    rdata_o  = '0;
    rflags_o = '0;
    if (!rst_i && rsp_real) begin
      rdata_o  = fpu_rdata_i;
      rflags_o = fpu_rflags_i;
    end else if (!rst_i && wdog_fire) begin
      rdata_o  = CANON_NAN;
      rflags_o = FLAG_NV;
    end
  end

  assign spurious_o = ~rst_i & fpu_rvalid_i & fifo_empty;
  assign busy_o     = ~rst_i & (state_q != ARB_IDLE);

  fpu_arb_owner_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (IW)
  ) u_owner_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (grant),
    .pop   (pop),
    .wdata (sel),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i)      rr_q <= '0;
    else if (grant) rr_q <= (sel == IW'(NUM_REQ-1)) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    cnt_nxt = count;
    if (grant && !pop)      cnt_nxt = count + 1'b1;
    else if (pop && !grant) cnt_nxt = count - 1'b1;
    state_d = ARB_ACTIVE;
    if (cnt_nxt == '0)                  state_d = ARB_IDLE;
    else if (cnt_nxt == CW'(MAX_OUTST)) state_d = ARB_FULL;
  end

`ifdef FPU_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  logic [WW-1:0] wdog_cnt_q;
  logic          wdog_err_q;

  // Fires on the WDOG_CYCLES-th consecutive silent cycle; a real response wins.
  assign wdog_fire  = has_owner & ~fpu_rvalid_i & (wdog_cnt_q == WW'(WDOG_CYCLES-1));
  assign wdog_err_o = ~rst_i & (wdog_err_q | wdog_fire);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (fpu_rvalid_i || !has_owner || wdog_fire) wdog_cnt_q <= '0;
      else                                         wdog_cnt_q <= wdog_cnt_q + 1'b1;
      if (wdog_fire) wdog_err_q <= 1'b1;
    end
  end
`else
  logic wdog_unused;
  assign wdog_unused = ^WDOG_CYCLES;
  assign wdog_fire   = 1'b0;
  assign wdog_err_o  = 1'b0;
`endif
endmodule
